// File: rtl/vh_expr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : vh_expr_pipe_if
// Brief   : Valid/ready transaction bundle between a driver and vh_expr_pipe.
// Rev     : 1.0  initial release
// ============================================================================
interface vh_expr_pipe_if #(
  parameter int WA = 4,
  parameter int WB = 5,
  parameter int WY = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [WY-1:0] out_y;
  logic          out_ovf;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/vh_expr_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vh_expr_pipe
// Brief   : Two-stage elastic pipeline evaluating one Verilog-semantics
//           binary/reduction expression per transaction.
// Rev     : 1.0  initial release
// ============================================================================
module vh_expr_pipe #(
  parameter int WA = 4,
  parameter int WB = 5,
  parameter int WY = 6,
  parameter bit SA = 1'b1,
  parameter bit SB = 1'b1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  vh_expr_pipe_if.slave bus
);

  localparam int WAB  = (WA > WB) ? WA : WB;
  localparam int WC   = (WAB > WY) ? WAB : WY;
  localparam int WE   = WC + 2;
  localparam bit SCTX = SA && SB;

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_mul  = 4'd2;
  localparam logic [3:0] c_op_and  = 4'd3;
  localparam logic [3:0] c_op_or   = 4'd4;
  localparam logic [3:0] c_op_xor  = 4'd5;
  localparam logic [3:0] c_op_xnor = 4'd6;
  localparam logic [3:0] c_op_shl  = 4'd7;
  localparam logic [3:0] c_op_shr  = 4'd8;
  localparam logic [3:0] c_op_ashr = 4'd9;
  localparam logic [3:0] c_op_eq   = 4'd10;
  localparam logic [3:0] c_op_lt   = 4'd11;
  localparam logic [3:0] c_op_le   = 4'd12;
  localparam logic [3:0] c_op_rand = 4'd13;
  localparam logic [3:0] c_op_ror  = 4'd14;
  localparam logic [3:0] c_op_rxor = 4'd15;

  logic          s1_valid_q;
  logic [3:0]    s1_op_q;
  logic [WC-1:0] s1_a_q, s1_b_q;
  logic [WC-1:0] s1_a_d, s1_b_d;

  logic          out_valid_q, out_ovf_q, out_ovf_d;
  logic [WY-1:0] out_y_q, out_y_d;

  logic          w_s1_load, w_s2_load;

  assign w_s2_load    = !out_valid_q || bus.out_ready;
  assign w_s1_load    = !s1_valid_q || w_s2_load;
  assign bus.in_ready = w_s1_load;

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_ovf   = out_ovf_q;

  // Both operands share one extension rule: signed only if both are signed.
  always_comb begin
    s1_a_d = SCTX ? WC'($signed(bus.in_a)) : WC'(bus.in_a);
    s1_b_d = SCTX ? WC'($signed(bus.in_b)) : WC'(bus.in_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (w_s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_q <= bus.in_op;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
      end
    end
  end

  // Overflow is judged on the exact WE-bit result against the WY-bit range.
  function automatic logic f_ovf(input logic [WE-1:0] v);
    if (SCTX) begin
      f_ovf = !((&v[WE-1:WY-1]) || !(|v[WE-1:WY-1]));
    end else begin
      f_ovf = |v[WE-1:WY];
    end
  endfunction

  logic [WE-1:0] w_a_wide, w_b_wide, w_sum_wide, w_dif_wide;
  logic [WC-1:0] w_res;
  logic [31:0]   w_amt;
  logic          w_lt, w_le;

  always_comb begin
    w_a_wide   = SCTX ? WE'($signed(s1_a_q)) : WE'(s1_a_q);
    w_b_wide   = SCTX ? WE'($signed(s1_b_q)) : WE'(s1_b_q);
    w_sum_wide = w_a_wide + w_b_wide;
    w_dif_wide = w_a_wide - w_b_wide;
    w_amt      = 32'(s1_b_q[WB-1:0]);
    w_lt       = SCTX ? ($signed(s1_a_q) <  $signed(s1_b_q)) : (s1_a_q <  s1_b_q);
    w_le       = SCTX ? ($signed(s1_a_q) <= $signed(s1_b_q)) : (s1_a_q <= s1_b_q);

    w_res = '0;
    case (s1_op_q)
      c_op_add:  w_res = w_sum_wide[WC-1:0];
      c_op_sub:  w_res = w_dif_wide[WC-1:0];
      c_op_mul:  w_res = s1_a_q * s1_b_q;
      c_op_and:  w_res = s1_a_q & s1_b_q;
      c_op_or:   w_res = s1_a_q | s1_b_q;
      c_op_xor:  w_res = s1_a_q ^ s1_b_q;
      c_op_xnor: w_res = ~(s1_a_q ^ s1_b_q);
      c_op_shl:  w_res = (w_amt >= 32'(WC)) ? '0 : (s1_a_q << w_amt);
      c_op_shr:  w_res = (w_amt >= 32'(WC)) ? '0 : (s1_a_q >> w_amt);
      c_op_ashr: w_res = SCTX ? WC'($signed(s1_a_q) >>> w_amt) : (s1_a_q >> w_amt);
      c_op_eq:   w_res = WC'(s1_a_q == s1_b_q);
      c_op_lt:   w_res = WC'(w_lt);
      c_op_le:   w_res = WC'(w_le);
      c_op_rand: w_res = WC'(&s1_a_q[WA-1:0]);
      c_op_ror:  w_res = WC'(|s1_a_q[WA-1:0]);
      c_op_rxor: w_res = WC'(^s1_a_q[WA-1:0]);
      default:   w_res = '0;
    endcase

    out_y_d = w_res[WY-1:0];
    if (s1_op_q == c_op_add) begin
      out_ovf_d = f_ovf(w_sum_wide);
    end else if (s1_op_q == c_op_sub) begin
      out_ovf_d = f_ovf(w_dif_wide);
    end else begin
      out_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else if (w_s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_y_q   <= out_y_d;
        out_ovf_q <= out_ovf_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vh_expr_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_vh_expr_pipe
// Brief   : Self-checking bench: three parameter variants driven in lockstep.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vh_expr_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_ordy = 1'b1;
  logic [3:0] drv_op = '0;
  logic [3:0] drv_a = '0;
  logic [4:0] drv_b = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Variant 0: defaults; 1: SB=0 (unsigned context); 2: WY=4.
  vh_expr_pipe_if #(.WA(4), .WB(5), .WY(6)) bus0 ();
  vh_expr_pipe_if #(.WA(4), .WB(5), .WY(6)) bus1 ();
  vh_expr_pipe_if #(.WA(4), .WB(5), .WY(4)) bus2 ();

  vh_expr_pipe #(.WA(4), .WB(5), .WY(6), .SA(1'b1), .SB(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  vh_expr_pipe #(.WA(4), .WB(5), .WY(6), .SA(1'b1), .SB(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  vh_expr_pipe #(.WA(4), .WB(5), .WY(4), .SA(1'b1), .SB(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.in_valid = drv_valid; assign bus0.in_op = drv_op; assign bus0.in_a = drv_a;
  assign bus0.in_b = drv_b;         assign bus0.out_ready = drv_ordy;
  assign bus1.in_valid = drv_valid; assign bus1.in_op = drv_op; assign bus1.in_a = drv_a;
  assign bus1.in_b = drv_b;         assign bus1.out_ready = drv_ordy;
  assign bus2.in_valid = drv_valid; assign bus2.in_op = drv_op; assign bus2.in_a = drv_a;
  assign bus2.in_b = drv_b;         assign bus2.out_ready = drv_ordy;

  logic [5:0] got_y   [3];
  logic       got_ovf [3];
  logic       got_vld [3];
  logic       got_rdy [3];
  assign got_y[0] = bus0.out_y;           assign got_ovf[0] = bus0.out_ovf;
  assign got_y[1] = bus1.out_y;           assign got_ovf[1] = bus1.out_ovf;
  assign got_y[2] = {2'b00, bus2.out_y};  assign got_ovf[2] = bus2.out_ovf;
  assign got_vld[0] = bus0.out_valid; assign got_rdy[0] = bus0.in_ready;
  assign got_vld[1] = bus1.out_valid; assign got_rdy[1] = bus1.in_ready;
  assign got_vld[2] = bus2.out_valid; assign got_rdy[2] = bus2.in_ready;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical operand values.
  function automatic logic [6:0] model(input int k, input logic [3:0] op,
                                       input logic [3:0] a, input logic [4:0] b);
    int     wy;
    int     wc;
    bit     sctx;
    bit     ovf;
    longint av, bv, ea, eb, r, mwc, lo, hi;
    int     amt;
    wy   = (k == 2) ? 4 : 6;
    wc   = (wy > 5) ? wy : 5;
    sctx = (k != 1);
    av   = sctx ? longint'($signed(a)) : longint'(a);
    bv   = sctx ? longint'($signed(b)) : longint'(b);
    mwc  = (longint'(1) << wc) - 1;
    ea   = av & mwc;
    eb   = bv & mwc;
    amt  = int'(b);
    ovf  = 1'b0;
    r    = 0;
    case (op)
      4'd0, 4'd1: begin
        r = (op == 4'd0) ? av + bv : av - bv;
        if (sctx) begin
          lo = -(longint'(1) << (wy - 1));
          hi = (longint'(1) << (wy - 1)) - 1;
        end else begin
          lo = 0;
          hi = (longint'(1) << wy) - 1;
        end
        ovf = (r < lo) || (r > hi);
      end
      4'd2:  r = av * bv;
      4'd3:  r = ea & eb;
      4'd4:  r = ea | eb;
      4'd5:  r = ea ^ eb;
      4'd6:  r = ~(ea ^ eb);
      4'd7:  r = (amt >= wc) ? 0 : (ea << amt);
      4'd8:  r = (amt >= wc) ? 0 : (ea >> amt);
      4'd9:  r = sctx ? (av >>> ((amt >= wc) ? wc : amt)) : ((amt >= wc) ? 0 : (ea >> amt));
      4'd10: r = longint'(av == bv);
      4'd11: r = longint'(av < bv);
      4'd12: r = longint'(av <= bv);
      4'd13: r = longint'(a == 4'hF);
      4'd14: r = longint'(a != 4'h0);
      default: r = longint'($countones(a) % 2);
    endcase
    r = r & ((longint'(1) << wy) - 1);
    return {r[5:0], ovf};
  endfunction

  typedef struct {
    int         inst;
    logic [3:0] op;
    logic [3:0] a;
    logic [4:0] b;
    logic [5:0] y;
    logic       ovf;
  } vec_t;

  // Streams n transactions; pattern=1 gives back-to-back ADDs with out_ready 1,0,0,1.
  task automatic run_stream(input int n, input bit pattern);
    logic [20:0] q[$];
    logic [20:0] ent;
    logic [3:0]  cop, ca;
    logic [4:0]  cb;
    logic [5:0]  prev_y = '0;
    bit          prev_stall = 1'b0;
    bit          acc, cons, exp_rdy;
    int          sent = 0, got = 0, cyc = 0, occ = 0;
    bit          patt [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    cop = pattern ? 4'd0 : 4'($urandom_range(0, 15));
    ca  = pattern ? 4'd5 : 4'($urandom);
    cb  = pattern ? 5'd9 : 5'($urandom);
    while (got < n && cyc < n * 10 + 50) begin
      drv_valid = (sent < n) && (pattern || ($urandom_range(0, 3) != 0));
      drv_op = cop; drv_a = ca; drv_b = cb;
      drv_ordy = pattern ? patt[cyc % 4] : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_rdy = !(occ == 2 && !drv_ordy);
      chk("in_ready", 32'(got_rdy[0]), 32'(exp_rdy));
      if (prev_stall && got_vld[0]) chk("stall_hold", 32'(got_y[0]), 32'(prev_y));
      if (got_vld[0]) chk("valid_nonempty", 32'(q.size() != 0), 32'd1);
      acc  = drv_valid && got_rdy[0];
      cons = got_vld[0] && drv_ordy;
      if (cons && q.size() != 0) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("strm%0d_y", k),   32'(got_y[k]),   32'(q[0][k*7+1 +: 6]));
          chk($sformatf("strm%0d_ovf", k), 32'(got_ovf[k]), 32'(q[0][k*7]));
        end
        got++;
      end
      prev_stall = got_vld[0] && !drv_ordy;
      prev_y     = got_y[0];
      @(posedge clk);
      if (acc) begin
        ent = {model(2, cop, ca, cb), model(1, cop, ca, cb), model(0, cop, ca, cb)};
        q.push_back(ent);
        sent++; occ++;
        cop = pattern ? 4'd0 : 4'($urandom_range(0, 15));
        ca  = pattern ? 4'(sent * 3 + 5) : 4'($urandom);
        cb  = pattern ? 5'(sent * 7 + 9) : 5'($urandom);
      end
      if (cons && q.size() != 0) begin
        void'(q.pop_front());
        occ--;
      end
      #1;
      cyc++;
    end
    chk("stream_count", 32'(got), 32'(n));
    drv_valid = 1'b0;
    drv_ordy  = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t     vecs [21];
    logic [6:0] m;
    vecs[0]  = '{0, 4'd0,  4'h8, 5'd3,  6'h3B, 1'b0};
    vecs[1]  = '{0, 4'd2,  4'hD, 5'd5,  6'h31, 1'b0};
    vecs[2]  = '{1, 4'd0,  4'h8, 5'd3,  6'h0B, 1'b0};
    vecs[3]  = '{1, 4'd11, 4'h8, 5'd3,  6'h00, 1'b0};
    vecs[4]  = '{0, 4'd11, 4'h8, 5'd3,  6'h01, 1'b0};
    vecs[5]  = '{0, 4'd9,  4'h8, 5'd2,  6'h3E, 1'b0};
    vecs[6]  = '{0, 4'd8,  4'h8, 5'd2,  6'h0E, 1'b0};
    vecs[7]  = '{0, 4'd7,  4'h1, 5'd6,  6'h00, 1'b0};
    vecs[8]  = '{0, 4'd0,  4'h7, 5'd15, 6'h16, 1'b0};
    vecs[9]  = '{2, 4'd1,  4'h8, 5'd15, 6'h09, 1'b1};
    vecs[10] = '{1, 4'd9,  4'h8, 5'd2,  6'h02, 1'b0};
    vecs[11] = '{0, 4'd6,  4'h8, 5'd3,  6'h04, 1'b0};
    vecs[12] = '{0, 4'd15, 4'h7, 5'd0,  6'h01, 1'b0};
    vecs[13] = '{0, 4'd7,  4'h1, 5'd5,  6'h20, 1'b0};
    vecs[14] = '{0, 4'd12, 4'h8, 5'h18, 6'h01, 1'b0};
    vecs[15] = '{0, 4'd10, 4'h8, 5'h18, 6'h01, 1'b0};
    vecs[16] = '{1, 4'd1,  4'h0, 5'd1,  6'h3F, 1'b1};
    vecs[17] = '{2, 4'd0,  4'h7, 5'd0,  6'h07, 1'b0};
    vecs[18] = '{1, 4'd10, 4'h8, 5'h18, 6'h00, 1'b0};
    vecs[19] = '{0, 4'd1,  4'h8, 5'd15, 6'h29, 1'b0};
    vecs[20] = '{2, 4'd0,  4'h7, 5'd1,  6'h08, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(got_vld[0]), 32'd0);
    chk("rst_out_y",     32'(got_y[0]),   32'd0);
    chk("rst_out_ovf",   32'(got_ovf[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(got_rdy[0]), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with latency check
    foreach (vecs[i]) begin
      drv_op = vecs[i].op; drv_a = vecs[i].a; drv_b = vecs[i].b;
      drv_valid = 1'b1; drv_ordy = 1'b1;
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), 32'(got_vld[vecs[i].inst]), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(got_vld[vecs[i].inst]), 32'd1);
      chk($sformatf("vec%0d_y", i),     32'(got_y[vecs[i].inst]),   32'(vecs[i].y));
      chk($sformatf("vec%0d_ovf", i),   32'(got_ovf[vecs[i].inst]), 32'(vecs[i].ovf));
    end
    @(posedge clk);
    #1;

    run_stream(8, 1'b1);
    run_stream(200, 1'b0);
    @(posedge clk);
    #1;

    // Reset with two transactions in flight
    drv_ordy = 1'b0;
    drv_valid = 1'b1; drv_op = 4'd0; drv_a = 4'h3; drv_b = 5'd4;
    @(posedge clk);
    #1;
    drv_a = 4'h5; drv_b = 5'd6;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    chk("full_in_ready", 32'(got_rdy[0]), 32'd0);
    chk("full_out_valid", 32'(got_vld[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(got_vld[0]), 32'd0);
    chk("midrst_out_y",     32'(got_y[0]),   32'd0);
    chk("midrst_out_ovf",   32'(got_ovf[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drv_ordy = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(got_rdy[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_no_stale", 32'(got_vld[0]), 32'd0);
    drv_valid = 1'b1; drv_op = 4'd1; drv_a = 4'h2; drv_b = 5'd9;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    chk("post_rst_early", 32'(got_vld[0]), 32'd0);
    @(posedge clk);
    #1;
    m = model(0, 4'd1, 4'h2, 5'd9);
    chk("post_rst_valid", 32'(got_vld[0]), 32'd1);
    chk("post_rst_y",     32'(got_y[0]),   32'(m[6:1]));
    chk("post_rst_ovf",   32'(got_ovf[0]), 32'(m[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
